// File: rtl/alk_mdseq.sv
// alk_mdseq -- multiply/divide step sequencer for the DC615 ALK datapath.
//
// Accepts a one-cycle start request (op + data size) while idle, then drives
// the Q shift-direction controls and ALPCTL decode lines for 8/16/32 step
// cycles. Divides may add a remainder-restore fixup cycle when the partial
// remainder is negative after the final step. Completion is a one-cycle
// done_h pulse in the DONE state.
//
// Ports:
//   clk_h                datapath clock, rising edge
//   reset_l              synchronous active-low reset
//   start_h              begin operation (sampled only in IDLE)
//   op_h[1:0]            00 none, 01 MUL, 10 DIV, 11 DIVDBL
//   dsize_l[1:0]         active-low DSIZE: ~dsize_l = 00 byte, 01 word, 1x long
//   stall_l              low freezes state, counter and outputs
//   abort_h              cancel operation in STEP/FIXUP
//   rem_neg_h            partial remainder sign on the last divide step
//   dq_q_shl_h           Q shift left (DIV/DIVDBL step)
//   dq_q_shr_h           Q shift right (MUL step)
//   alpctl_mul_l         low during MUL steps
//   alpctl_div_h         high during DIV/DIVDBL steps
//   alpctl_divdbl_l      low during DIVDBL steps
//   alpctl_div_divdbl_l  low during DIV/DIVDBL steps and the fixup cycle
//   alpctl_rem_l         low during the fixup cycle
//   busy_h               high outside IDLE
//   last_h               high on the final step
//   done_h               one-cycle completion pulse
//   step_cnt_h[5:0]      remaining steps including the current one

module alk_mdseq (
    input  logic       clk_h,
    input  logic       reset_l,
    input  logic       start_h,
    input  logic [1:0] op_h,
    input  logic [1:0] dsize_l,
    input  logic       stall_l,
    input  logic       abort_h,
    input  logic       rem_neg_h,
    output logic       dq_q_shl_h,
    output logic       dq_q_shr_h,
    output logic       alpctl_mul_l,
    output logic       alpctl_div_h,
    output logic       alpctl_divdbl_l,
    output logic       alpctl_div_divdbl_l,
    output logic       alpctl_rem_l,
    output logic       busy_h,
    output logic       last_h,
    output logic       done_h,
    output logic [5:0] step_cnt_h
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_STEP  = 2'b01,
        S_FIXUP = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_MUL    = 2'b01,
        OP_DIV    = 2'b10,
        OP_DIVDBL = 2'b11
    } op_e;

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] dsize_h;
    logic [5:0] load_cnt;

    logic shl_q, shl_d;
    logic shr_q, shr_d;
    logic mul_l_q, mul_l_d;
    logic div_q, div_d;
    logic divdbl_l_q, divdbl_l_d;
    logic dd_l_q, dd_l_d;
    logic rem_l_q, rem_l_d;
    logic busy_q, busy_d;
    logic last_q, last_d;
    logic done_q, done_d;

    assign dsize_h = ~dsize_l;

    // DIVDBL always works on a quadword dividend / longword quotient.
    always_comb begin
        load_cnt = 6'd32;
        if (op_e'(op_h) != OP_DIVDBL) begin
            case (dsize_h)
                2'b00:   load_cnt = 6'd8;
                2'b01:   load_cnt = 6'd16;
                default: load_cnt = 6'd32;
            endcase
        end
    end

    // Next-state and counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_h && (op_e'(op_h) != OP_NONE)) begin
                    op_d    = op_e'(op_h);
                    cnt_d   = load_cnt;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (abort_h) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (stall_l) begin
                    if (cnt_q == 6'd1) begin
                        cnt_d   = '0;
                        state_d = ((op_q != OP_MUL) && rem_neg_h) ? S_FIXUP : S_DONE;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            S_FIXUP: begin
                if (abort_h) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (stall_l) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (stall_l) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear registered,
    // one cycle after the start edge, with no path from start_h.
    always_comb begin
        logic in_step;
        logic is_mul;
        logic is_div;
        in_step    = (state_d == S_STEP);
        is_mul     = (op_d == OP_MUL);
        is_div     = (op_d == OP_DIV) || (op_d == OP_DIVDBL);
        shr_d      = in_step && is_mul;
        shl_d      = in_step && is_div;
        mul_l_d    = !(in_step && is_mul);
        div_d      = in_step && is_div;
        divdbl_l_d = !(in_step && (op_d == OP_DIVDBL));
        dd_l_d     = !((in_step && is_div) || (state_d == S_FIXUP));
        rem_l_d    = !(state_d == S_FIXUP);
        busy_d     = (state_d != S_IDLE);
        last_d     = in_step && (cnt_d == 6'd1);
        // A stall in DONE stretches the state but done_h pulses only on entry.
        done_d     = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk_h) begin
        if (!reset_l) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NONE;
            cnt_q      <= '0;
            shl_q      <= 1'b0;
            shr_q      <= 1'b0;
            mul_l_q    <= 1'b1;
            div_q      <= 1'b0;
            divdbl_l_q <= 1'b1;
            dd_l_q     <= 1'b1;
            rem_l_q    <= 1'b1;
            busy_q     <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            shl_q      <= shl_d;
            shr_q      <= shr_d;
            mul_l_q    <= mul_l_d;
            div_q      <= div_d;
            divdbl_l_q <= divdbl_l_d;
            dd_l_q     <= dd_l_d;
            rem_l_q    <= rem_l_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

    assign dq_q_shl_h          = shl_q;
    assign dq_q_shr_h          = shr_q;
    assign alpctl_mul_l        = mul_l_q;
    assign alpctl_div_h        = div_q;
    assign alpctl_divdbl_l     = divdbl_l_q;
    assign alpctl_div_divdbl_l = dd_l_q;
    assign alpctl_rem_l        = rem_l_q;
    assign busy_h              = busy_q;
    assign last_h              = last_q;
    assign done_h              = done_q;
    assign step_cnt_h          = cnt_q;

endmodule

// File: tb/tb_alk_mdseq.sv
// Self-checking bench for alk_mdseq. Each scenario is expanded into a
// per-cycle list of expected output vectors and the inputs to drive that
// cycle, then played against the DUT.
module tb_alk_mdseq;

    logic       clk_h = 1'b0;
    logic       reset_l = 1'b0;
    logic       start_h = 1'b0;
    logic [1:0] op_h = 2'b00;
    logic [1:0] dsize_l = 2'b11;
    logic       stall_l = 1'b1;
    logic       abort_h = 1'b0;
    logic       rem_neg_h = 1'b0;
    logic       dq_q_shl_h, dq_q_shr_h, alpctl_mul_l, alpctl_div_h;
    logic       alpctl_divdbl_l, alpctl_div_divdbl_l, alpctl_rem_l;
    logic       busy_h, last_h, done_h;
    logic [5:0] step_cnt_h;

    int vectors = 0;
    int miscompares = 0;

    alk_mdseq dut (
        .clk_h(clk_h), .reset_l(reset_l), .start_h(start_h), .op_h(op_h),
        .dsize_l(dsize_l), .stall_l(stall_l), .abort_h(abort_h),
        .rem_neg_h(rem_neg_h), .dq_q_shl_h(dq_q_shl_h), .dq_q_shr_h(dq_q_shr_h),
        .alpctl_mul_l(alpctl_mul_l), .alpctl_div_h(alpctl_div_h),
        .alpctl_divdbl_l(alpctl_divdbl_l), .alpctl_div_divdbl_l(alpctl_div_divdbl_l),
        .alpctl_rem_l(alpctl_rem_l), .busy_h(busy_h), .last_h(last_h),
        .done_h(done_h), .step_cnt_h(step_cnt_h)
    );

    always #5 clk_h = ~clk_h;

    // Vector layout: busy, done, last, shr, shl, mul_l, div_h, divdbl_l,
    // div_divdbl_l, rem_l, step_cnt[5:0].
    typedef struct {
        logic [15:0] exp;
        bit          start;
        bit          stall;
        bit          abort;
        bit          rst;
        bit          noise;
        bit          remv;
        logic [1:0]  op;
        logic [1:0]  dsz;
    } rec_t;

    rec_t q[$];

    function automatic logic [15:0] idle_v();
        return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0};
    endfunction

    function automatic logic [15:0] step_v(input int op, input int k);
        logic [5:0] c;
        c = 6'(k);
        return {1'b1, 1'b0, (k == 1), (op == 1), (op != 1), (op != 1), (op != 1),
                (op != 3), (op == 1), 1'b1, c};
    endfunction

    function automatic logic [15:0] fixup_v();
        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    endfunction

    function automatic logic [15:0] done_v(input bit d);
        return {1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0};
    endfunction

    function automatic rec_t mk(input logic [15:0] e);
        rec_t r;
        r.exp = e; r.start = 0; r.stall = 0; r.abort = 0; r.rst = 0;
        r.noise = 0; r.remv = 1'($urandom); r.op = 2'b00; r.dsz = 2'b00;
        return r;
    endfunction

    function automatic logic [15:0] sample();
        return {busy_h, done_h, last_h, dq_q_shr_h, dq_q_shl_h, alpctl_mul_l,
                alpctl_div_h, alpctl_divdbl_l, alpctl_div_divdbl_l, alpctl_rem_l,
                step_cnt_h};
    endfunction

    // Expands one operation into its expected cycle trace.
    // stall_at/kill_at count steps from 1; kill_at = N+1 targets the fixup
    // cycle. kill_kind 1 = abort, 2 = reset.
    task automatic build(input int op, input logic [1:0] dsz, input bit remneg,
                         input int stall_at, input int stall_len, input int kill_at,
                         input int kill_kind, input int done_stall, input bit noise);
        int n;
        logic [1:0] dh;
        rec_t r;
        q.delete();
        dh = ~dsz;
        n = (op == 3) ? 32 : (dh == 2'b00) ? 8 : (dh == 2'b01) ? 16 : 32;
        r = mk(idle_v()); r.start = 1; r.op = 2'(op); r.dsz = dsz;
        q.push_back(r);
        for (int k = n; k >= 1; k--) begin
            int idx;
            idx = n - k + 1;
            if (idx == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    r = mk(step_v(op, k)); r.stall = 1; r.noise = noise;
                    if (k == 1) r.remv = remneg;
                    q.push_back(r);
                end
            end
            r = mk(step_v(op, k)); r.noise = noise;
            if (k == 1) r.remv = remneg;
            if (idx == kill_at) begin
                r.stall = 1'($urandom);
                if (kill_kind == 1) r.abort = 1; else r.rst = 1;
                q.push_back(r);
                q.push_back(mk(idle_v()));
                return;
            end
            q.push_back(r);
        end
        if (op != 1 && remneg) begin
            r = mk(fixup_v()); r.noise = noise;
            if (kill_at == n + 1) begin
                r.abort = 1;
                q.push_back(r);
                q.push_back(mk(idle_v()));
                return;
            end
            q.push_back(r);
        end
        if (done_stall > 0) begin
            r = mk(done_v(1)); r.stall = 1; r.abort = 1'($urandom); q.push_back(r);
            for (int s = 1; s < done_stall; s++) begin
                r = mk(done_v(0)); r.stall = 1; r.abort = 1'($urandom); q.push_back(r);
            end
            r = mk(done_v(0)); r.abort = 1'($urandom); q.push_back(r);
        end else begin
            r = mk(done_v(1)); r.abort = 1'($urandom); r.noise = noise; q.push_back(r);
        end
        q.push_back(mk(idle_v()));
    endtask

    // Samples the cycle after the next edge, then drives that cycle's inputs.
    task automatic apply_rec(input rec_t r, output logic [15:0] obs);
        @(posedge clk_h);
        #1;
        obs = sample();
        reset_l   = !r.rst;
        stall_l   = !r.stall;
        abort_h   = r.abort;
        rem_neg_h = r.remv;
        if (r.start) begin
            start_h = 1'b1; op_h = r.op; dsize_l = r.dsz;
        end else begin
            start_h = r.noise ? 1'($urandom) : 1'b0;
            op_h    = 2'($urandom);
            dsize_l = 2'($urandom);
        end
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        reset_l = 0; start_h = 1; op_h = 2'b01; dsize_l = 2'b11;
        abort_h = 1; stall_l = 0; rem_neg_h = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_h); #1;
            obs = sample(); vectors++;
            if (obs !== idle_v()) begin
                miscompares++;
                $display("FAIL reset[%0d] got %h exp %h", i, obs, idle_v());
            end
        end
        reset_l = 1; start_h = 0; abort_h = 0; stall_l = 1; rem_neg_h = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_h); #1;
            obs = sample(); vectors++;
            if (obs !== idle_v()) begin
                miscompares++;
                $display("FAIL reset_release[%0d] got %h exp %h", i, obs, idle_v());
            end
        end
    endtask

    task automatic test_op_none();
        logic [15:0] obs;
        rec_t r;
        q.delete();
        r = mk(idle_v()); r.start = 1; r.op = 2'b00; r.dsz = 2'b00; q.push_back(r);
        for (int i = 0; i < 3; i++) q.push_back(mk(idle_v()));
        foreach (q[i]) begin
            apply_rec(q[i], obs); vectors++;
            if (obs !== q[i].exp) begin
                miscompares++;
                $display("FAIL op_none[%0d] got %h exp %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_mul_byte();
        logic [15:0] obs;
        build(1, 2'b11, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        foreach (q[i]) begin
            apply_rec(q[i], obs); vectors++;
            if (obs !== q[i].exp) begin
                miscompares++;
                $display("FAIL mul_byte[%0d] got %h exp %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_div_fixup();
        logic [15:0] obs;
        for (int rn = 1; rn >= 0; rn--) begin
            build(2, 2'b10, 1'(rn), 0, 0, 0, 0, 0, 1'b0);
            foreach (q[i]) begin
                apply_rec(q[i], obs); vectors++;
                if (obs !== q[i].exp) begin
                    miscompares++;
                    $display("FAIL div_word_rem%0d[%0d] got %h exp %h", rn, i, obs, q[i].exp);
                end
            end
        end
    endtask

    task automatic test_divdbl();
        logic [15:0] obs;
        build(3, 2'b11, 1'($urandom), 0, 0, 0, 0, 0, 1'b0);
        foreach (q[i]) begin
            apply_rec(q[i], obs); vectors++;
            if (obs !== q[i].exp) begin
                miscompares++;
                $display("FAIL divdbl[%0d] got %h exp %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] obs;
        build(1, 2'b00, 1'b0, 12, 3, 0, 0, 2, 1'b0);
        foreach (q[i]) begin
            apply_rec(q[i], obs); vectors++;
            if (obs !== q[i].exp) begin
                miscompares++;
                $display("FAIL stall_mul_long[%0d] got %h exp %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [15:0] obs;
        build(2, 2'b00, 1'b0, 0, 0, 5, 1, 0, 1'b0);
        foreach (q[i]) begin
            apply_rec(q[i], obs); vectors++;
            if (obs !== q[i].exp) begin
                miscompares++;
                $display("FAIL abort_step5[%0d] got %h exp %h", i, obs, q[i].exp);
            end
        end
        build(2, 2'b11, 1'b1, 0, 0, 9, 1, 0, 1'b0);
        foreach (q[i]) begin
            apply_rec(q[i], obs); vectors++;
            if (obs !== q[i].exp) begin
                miscompares++;
                $display("FAIL abort_fixup[%0d] got %h exp %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [15:0] obs;
        build(1, 2'b10, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        foreach (q[i]) begin
            apply_rec(q[i], obs); vectors++;
            if (obs !== q[i].exp) begin
                miscompares++;
                $display("FAIL busy_start[%0d] got %h exp %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] obs;
        build(2, 2'b00, 1'b1, 0, 0, 10, 2, 0, 1'b0);
        foreach (q[i]) begin
            apply_rec(q[i], obs); vectors++;
            if (obs !== q[i].exp) begin
                miscompares++;
                $display("FAIL reset_mid[%0d] got %h exp %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] obs;
        for (int t = 0; t < 25; t++) begin
            int op, stall_at, kill_at, kind;
            op       = int'($urandom_range(1, 3));
            stall_at = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 32));
            kill_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0;
            kind     = int'($urandom_range(1, 2));
            build(op, 2'($urandom), 1'($urandom), stall_at, int'($urandom_range(1, 4)),
                  kill_at, kind, int'($urandom_range(0, 2)), 1'($urandom));
            foreach (q[i]) begin
                apply_rec(q[i], obs); vectors++;
                if (obs !== q[i].exp) begin
                    miscompares++;
                    $display("FAIL random%0d_op%0d[%0d] got %h exp %h", t, op, i, obs, q[i].exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_op_none();
        test_mul_byte();
        test_div_fixup();
        test_divdbl();
        test_stall();
        test_abort();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
